// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-request load/store unit in front of a word-wide data
//                memory with 1-cycle synchronous read. Checks alignment and
//                range, does read-modify-write for byte/half stores and
//                sign/zero-extends load results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int                     DATA_WIDTH = 32,
    parameter int                     ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 32'h1000,
    parameter int                     MEM_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [ADDR_WIDTH-1:0] c_RANGE_BYTES = ADDR_WIDTH'(4 * MEM_WORDS);
    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR      = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [1:0]      r_lane;
    logic [15:0]     r_wdata;

    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_err;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_merged;

    assign req_ready = (r_state == ST_IDLE);

    // Subtracting first keeps the range check free of overflow near the top of the address space.
    assign w_offset = req_addr - BASE_ADDR;
    assign w_err    = (req_size == 2'b11)
                   || ((req_size == c_SIZE_HALF) && req_addr[0])
                   || ((req_size == c_SIZE_WORD) && (req_addr[1:0] != 2'b00))
                   || (w_offset >= c_RANGE_BYTES);

    always_comb begin
        w_byte   = mem_dout[7:0];
        w_half   = r_lane[1] ? mem_dout[31:16] : mem_dout[15:0];
        w_load   = mem_dout;
        w_merged = mem_dout;
        case (r_lane)
            2'd1:    w_byte = mem_dout[15:8];
            2'd2:    w_byte = mem_dout[23:16];
            2'd3:    w_byte = mem_dout[31:24];
            default: w_byte = mem_dout[7:0];
        endcase
        case (r_size)
            c_SIZE_BYTE: begin
                w_load = {{(DATA_WIDTH-8){w_byte[7] & ~r_unsigned}}, w_byte};
                w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
            end
            c_SIZE_HALF: begin
                w_load = {{(DATA_WIDTH-16){w_half[15] & ~r_unsigned}}, w_half};
                w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_lane     <= 2'b00;
            r_wdata    <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
        end else begin
            // Response and write strobe are single-cycle; only the arms below raise them.
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_lane     <= req_addr[1:0];
                        r_wdata    <= req_wdata[15:0];
                        if (w_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            r_state   <= ST_RESP;
                        end else begin
                            mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            if (req_we && (req_size == c_SIZE_WORD)) begin
                                mem_din   <= req_wdata;
                                mem_wr_en <= 1'b1;
                                r_state   <= ST_WR;
                            end else begin
                                r_state <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    r_state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (r_we) begin
                        mem_din   <= w_merged;
                        mem_wr_en <= 1'b1;
                        r_state   <= ST_WR;
                    end else begin
                        rsp_rdata <= w_load;
                        rsp_valid <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_WR: begin
                    rsp_valid <= 1'b1;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Scoreboard bench for load_store_unit with a byte-level
//                reference memory and a synchronous-read data memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam logic [31:0] c_BASE  = 32'h1000;
    localparam int          c_WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    load_store_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (c_BASE),
        .MEM_WORDS  (c_WORDS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int w);
        return (w * 32'h9E3779B9) + 32'h01234567;
    endfunction

    // Data memory: 1-cycle synchronous read, contents seeded on the first edge (during reset).
    logic [31:0] mem [c_WORDS];
    logic        mem_seeded = 1'b0;
    logic [31:0] mem_off;
    assign mem_off = mem_addr - c_BASE;

    always @(posedge clk) begin
        if (!mem_seeded) begin
            for (int w = 0; w < c_WORDS; w++) mem[w] <= init_word(w);
            mem_seeded <= 1'b1;
            mem_dout   <= 32'h0;
        end else if (mem_off < 4 * c_WORDS) begin
            if (mem_wr_en) mem[mem_off[11:2]] <= mem_din;
            mem_dout <= mem[mem_off[11:2]];
        end else begin
            mem_dout <= 32'h0;
        end
    end

    // Reference: plain byte array, little-endian.
    logic [7:0] ref_mem [4*c_WORDS];

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
    } rsp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    rsp_t m_rsp;
    wr_t  m_wr;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wd, input int acc);
        rsp_t        e;
        wr_t         w;
        logic [31:0] off;
        int          nb;
        logic [31:0] v;
        off   = addr - c_BASE;
        nb    = 1 << size;
        e.acc = acc;
        e.err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                (size == 2'd2 && addr[1:0] != 2'b00) || (off >= 4 * c_WORDS);
        e.rdata = 32'h0;
        if (e.err) begin
            e.lat = 1;
        end else if (!we) begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[int'(off) + i]) << (8 * i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            e.rdata = v;
            e.lat   = 3;
        end else begin
            for (int i = 0; i < nb; i++) ref_mem[int'(off) + i] = wd[8*i +: 8];
            off    = off & 32'hFFFF_FFFC;
            w.addr = c_BASE + off;
            w.data = 32'h0;
            for (int i = 0; i < 4; i++) w.data = w.data | (32'(ref_mem[int'(off) + i]) << (8 * i));
            wr_q.push_back(w);
            e.lat = (nb == 4) ? 2 : 4;
        end
        rsp_q.push_back(e);
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit track);
        int n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        if (track) model(we, size, uns, addr, wd, cyc);
    endtask

    // Monitor: pops expected responses/writes as the DUT presents them.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                m_rsp = rsp_q.pop_front();
                check("rsp_err",   32'(rsp_err), 32'(m_rsp.err));
                check("rsp_rdata", rsp_rdata, m_rsp.rdata);
                check("rsp_latency", 32'(cyc - m_rsp.acc + 1), 32'(m_rsp.lat));
            end
        end
        if (mem_wr_en) begin
            if (wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got write to %h expected none (cycle %0d)", mem_addr, cyc);
            end else begin
                m_wr = wr_q.pop_front();
                check("wr_addr", mem_addr, m_wr.addr);
                check("wr_data", mem_din, m_wr.data);
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'h0);
        check({tag, "_rsp_rdata"}, rsp_rdata,      32'h0);
        check({tag, "_mem_wr_en"}, 32'(mem_wr_en), 32'h0);
        check({tag, "_mem_addr"},  mem_addr,       32'h0);
        check({tag, "_mem_din"},   mem_din,        32'h0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          n;
        for (int w = 0; w < c_WORDS; w++) begin
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_word(w) >> (8 * b);
        end

        // Reset held for 3 cycles, then idle.
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_mem_wr_en", 32'(mem_wr_en), 32'h0);
        end

        // Directed sequence.
        issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 1'b1);
        issue(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 1'b1);
        issue(1'b0, 2'd1, 1'b1, 32'h1000, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1);
        issue(1'b1, 2'd0, 1'b0, 32'h1001, 32'h00000055, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h1002, 32'h00001234, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h1002, 32'h0, 1'b1);
        issue(1'b1, 2'd1, 1'b0, 32'h1001, 32'h0000ABCD, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h0FFC, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 1'b1);
        issue(1'b0, 2'd3, 1'b0, 32'h1000, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h1FFC, 32'h0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1);

        // Reset pulsed while an RMW store sits in RD_DATA: no write, no response.
        issue(1'b1, 2'd0, 1'b0, 32'h1004, 32'h000000A5, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("abort_req_ready", 32'(req_ready), 32'h1);
        check("abort_mem_wr_en", 32'(mem_wr_en), 32'h0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_abort_req_ready", 32'(req_ready), 32'h1);
        issue(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 1'b1);

        // Randomized mix, biased toward a small hot region and the range edges.
        for (int k = 0; k < 300; k++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0:       a = c_BASE - 32'd4 + 32'($urandom_range(0, 7));
                1:       a = c_BASE + 4 * c_WORDS - 32'd4 + 32'($urandom_range(0, 7));
                2:       a = $urandom;
                3:       a = c_BASE + 32'($urandom_range(0, 4 * c_WORDS - 1));
                default: a = c_BASE + 32'($urandom_range(0, 31));
            endcase
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            issue(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
        end

        n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("pending_rsp", 32'(rsp_q.size()), 32'h0);
        check("pending_wr",  32'(wr_q.size()),  32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
